// File: rtl/hex_entry_if.sv
// Signal bundle between the hex entry buffer and its environment: switch/button
// inputs, the assembled word, and the downstream valid/ready handshake.
interface hex_entry_if #(
  parameter int NDIGITS = 16,
  parameter int DIGIT_W = 4
);
  localparam int CW = $clog2(NDIGITS + 1);

  logic [DIGIT_W-1:0]         din;
  logic                       load_n;
  logic                       backspace_n;
  logic                       clear_n;
  logic [NDIGITS*DIGIT_W-1:0] values;
  logic [CW-1:0]              n_entered;
  logic                       data_valid;
  logic                       data_ready;
  logic                       err;
  logic [2:0]                 state;

  // Handshake: a word transfers on a rising clk edge where data_valid and
  // data_ready are both high; values holds steady while data_valid is high,
  // and data_valid never drops without a transfer (or reset/backspace/clear).
  modport master (
    output din, load_n, backspace_n, clear_n, data_ready,
    input  values, n_entered, data_valid, err, state
  );

  modport slave (
    input  din, load_n, backspace_n, clear_n, data_ready,
    output values, n_entered, data_valid, err, state
  );
endinterface

// File: rtl/hex_entry_buffer.sv
// Collects switch digits into an NDIGITS-wide word under button control and
// offers the completed word downstream over a valid/ready handshake.
module hex_entry_buffer #(
  parameter int NDIGITS         = 16,
  parameter int DIGIT_W         = 4,
  parameter int CLEAR_ON_ACCEPT = 1
) (
  input  logic        clk,
  input  logic        rst,
  hex_entry_if.slave  hex_bus
);
  localparam int              CW    = $clog2(NDIGITS + 1);
  localparam int              VW    = NDIGITS * DIGIT_W;
  localparam logic [CW-1:0]   MAX_N = CW'(NDIGITS);
  localparam logic [CW-1:0]   ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_HELD  = 3'd1,
    BACK_HELD  = 3'd2,
    CLEAR_HELD = 3'd3,
    FULL       = 3'd4,
    ERR_HELD   = 3'd5
  } state_t;

  state_t          r_state;
  logic [VW-1:0]   r_values;
  logic [CW-1:0]   r_n;
  logic            r_err;
  logic            r_err_from_load;

  // Button bit order everywhere: {clear, backspace, load}
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_sync3;
  logic [2:0]      w_held;
  logic [2:0]      w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_sync3 <= '1;
    end else begin
      r_sync1 <= {hex_bus.clear_n, hex_bus.backspace_n, hex_bus.load_n};
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // A press acts once, on the first cycle its synchronised level is seen low.
  assign w_held  = ~r_sync2;
  assign w_press = ~r_sync2 & r_sync3;

  function automatic logic [VW-1:0] set_slot(input logic [VW-1:0]      v,
                                             input logic [CW-1:0]      k,
                                             input logic [DIGIT_W-1:0] d);
    logic [VW-1:0] res;
    res = v;
    for (int s = 0; s < NDIGITS; s++) begin
      if (k == CW'(s)) res[(NDIGITS-s)*DIGIT_W-1 -: DIGIT_W] = d;
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_values        <= '0;
      r_n             <= '0;
      r_err           <= 1'b0;
      r_err_from_load <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press[0]) begin
            if (r_n != MAX_N) begin
              r_values <= set_slot(r_values, r_n, hex_bus.din);
              r_n      <= r_n + ONE;
              r_state  <= LOAD_HELD;
            end else begin
              r_err           <= 1'b1;
              r_err_from_load <= 1'b1;
              r_state         <= ERR_HELD;
            end
          end else if (w_press[1]) begin
            if (r_n != '0) begin
              r_values <= set_slot(r_values, r_n - ONE, '0);
              r_n      <= r_n - ONE;
              r_state  <= BACK_HELD;
            end else begin
              r_err           <= 1'b1;
              r_err_from_load <= 1'b0;
              r_state         <= ERR_HELD;
            end
          end else if (w_press[2]) begin
            r_values <= '0;
            r_n      <= '0;
            r_state  <= CLEAR_HELD;
          end
        end
        LOAD_HELD: begin
          if (!w_held[0]) r_state <= (r_n == MAX_N) ? FULL : IDLE;
        end
        BACK_HELD: begin
          if (!w_held[1]) r_state <= IDLE;
        end
        CLEAR_HELD: begin
          if (!w_held[2]) r_state <= IDLE;
        end
        ERR_HELD: begin
          if (!(r_err_from_load ? w_held[0] : w_held[1])) r_state <= IDLE;
        end
        FULL: begin
          // FULL always holds NDIGITS digits, so backspace here cannot underflow.
          if (hex_bus.data_ready) begin
            if (CLEAR_ON_ACCEPT != 0) begin
              r_values <= '0;
              r_n      <= '0;
            end
            r_state <= IDLE;
          end else if (w_press[1]) begin
            r_values <= set_slot(r_values, r_n - ONE, '0);
            r_n      <= r_n - ONE;
            r_state  <= BACK_HELD;
          end else if (w_press[2]) begin
            r_values <= '0;
            r_n      <= '0;
            r_state  <= CLEAR_HELD;
          end
        end
        default: begin
          r_state <= IDLE;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign hex_bus.values     = r_values;
  assign hex_bus.n_entered  = r_n;
  assign hex_bus.data_valid = (r_state == FULL);
  assign hex_bus.err        = r_err;
  assign hex_bus.state      = r_state;
endmodule

// File: tb/tb_hex_entry_buffer.sv
// Bench for hex_entry_buffer: three instances (16x4 clear-on-accept, 16x4 keep,
// 4x8 clear-on-accept) share the buttons; completed words go through a scoreboard.
module tb_hex_entry_buffer;
  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1;
  logic       rst3;
  logic [7:0] din;
  logic       load_n;
  logic       bs_n;
  logic       clr_n;
  logic       rdy1;
  logic       rdy2;
  logic       rdy3;

  hex_entry_if #(.NDIGITS(16), .DIGIT_W(4)) if1 ();
  hex_entry_if #(.NDIGITS(16), .DIGIT_W(4)) if2 ();
  hex_entry_if #(.NDIGITS(4),  .DIGIT_W(8)) if3 ();

  assign if1.din = din[3:0];
  assign if2.din = din[3:0];
  assign if3.din = din;
  assign if1.load_n = load_n;
  assign if2.load_n = load_n;
  assign if3.load_n = load_n;
  assign if1.backspace_n = bs_n;
  assign if2.backspace_n = bs_n;
  assign if3.backspace_n = bs_n;
  assign if1.clear_n = clr_n;
  assign if2.clear_n = clr_n;
  assign if3.clear_n = clr_n;
  assign if1.data_ready = rdy1;
  assign if2.data_ready = rdy2;
  assign if3.data_ready = rdy3;

  hex_entry_buffer #(.NDIGITS(16), .DIGIT_W(4), .CLEAR_ON_ACCEPT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .hex_bus(if1));
  hex_entry_buffer #(.NDIGITS(16), .DIGIT_W(4), .CLEAR_ON_ACCEPT(0)) u_dut2 (
    .clk(clk), .rst(rst1), .hex_bus(if2));
  hex_entry_buffer #(.NDIGITS(4), .DIGIT_W(8), .CLEAR_ON_ACCEPT(1)) u_dut3 (
    .clk(clk), .rst(rst3), .hex_bus(if3));

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int err1_cnt = 0;
  int err2_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];
  logic dv1_d = 1'b0;
  logic dv3_d = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rising data_valid must match the next queued word.
  always @(negedge clk) begin
    if (if1.err) err1_cnt++;
    if (if2.err) err2_cnt++;
    if (if1.data_valid && !dv1_d) begin
      if (exp_q.size() == 0) check("sb1_extra_valid", W'(if1.data_valid), W'(0));
      else                   check("sb1_word", W'(if1.values), exp_q.pop_front());
    end
    if (if3.data_valid && !dv3_d) begin
      if (exp3_q.size() == 0) check("sb3_extra_valid", W'(if3.data_valid), W'(0));
      else                    check("sb3_word", W'(if3.values), exp3_q.pop_front());
    end
    dv1_d = if1.data_valid;
    dv3_d = if3.data_valid;
  end

  // ---------------- driver tasks ----------------
  // mask bits: {clear, backspace, load}
  task automatic press(input logic [2:0] mask, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    din = d;
    if (mask[0]) load_n = 1'b0;
    if (mask[1]) bs_n   = 1'b0;
    if (mask[2]) clr_n  = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    load_n = 1'b1;
    bs_n   = 1'b1;
    clr_n  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic reset1();
    @(posedge clk); #1;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_ready(input int which);
    @(posedge clk); #1;
    if (which == 1) rdy1 = 1'b1;
    if (which == 2) rdy2 = 1'b1;
    if (which == 3) rdy3 = 1'b1;
    @(posedge clk); #1;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    rdy3 = 1'b0;
  endtask

  logic [3:0] seq1 [16] = '{4'h1, 4'h3, 4'h3, 4'h4, 4'h5, 4'h7, 4'h7, 4'h9,
                            4'h9, 4'hB, 4'hB, 4'hC, 4'hD, 4'hF, 4'hF, 4'h1};
  logic [7:0] seq3 [4]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [W-1:0] word1 = 64'h133457799BBCDFF1;
  int e0;

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; din = '0;
    load_n = 1'b1; bs_n = 1'b1; clr_n = 1'b1;
    rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_values", W'(if1.values), W'(0));
    check("rst_n", W'(if1.n_entered), W'(0));
    check("rst_state", W'(if1.state), W'(0));
    check("rst_valid", W'(if1.data_valid), W'(0));
    check("rst_err", W'(if1.err), W'(0));
    rst1 = 1'b0;
    @(posedge clk); #1;

    // Full 16-digit entry; first press held 50 cycles writes one digit only.
    press(3'b001, 8'(seq1[0]), 50);
    check("hold_one_digit_n", W'(if1.n_entered), W'(1));
    check("hold_one_digit_slot0", W'(if1.values[63:60]), W'(4'h1));
    for (int i = 1; i < 16; i++) begin
      if (i == 15) exp_q.push_back(word1);
      press(3'b001, 8'(seq1[i]), 4);
    end
    check("full_values", W'(if1.values), word1);
    check("full_n", W'(if1.n_entered), W'(16));
    check("full_valid", W'(if1.data_valid), W'(1));
    check("full_state", W'(if1.state), W'(4));

    // Accept with clear-on-accept, then accept with contents retained.
    pulse_ready(1);
    check("acc1_valid", W'(if1.data_valid), W'(0));
    check("acc1_values", W'(if1.values), W'(0));
    check("acc1_n", W'(if1.n_entered), W'(0));
    check("acc2_pending_valid", W'(if2.data_valid), W'(1));
    pulse_ready(2);
    check("acc2_valid", W'(if2.data_valid), W'(0));
    check("acc2_values", W'(if2.values), word1);
    check("acc2_n", W'(if2.n_entered), W'(16));
    e0 = err2_cnt;
    press(3'b001, 8'h5, 4);
    check("acc2_load_err", W'(err2_cnt - e0), W'(1));
    check("acc2_load_values", W'(if2.values), word1);
    check("acc2_load_state", W'(if2.state), W'(0));
    check("acc1_next_load_n", W'(if1.n_entered), W'(1));

    // Backspace down to empty, error only on the underflowing press.
    reset1();
    press(3'b001, 8'hA, 4);
    press(3'b001, 8'hB, 4);
    press(3'b001, 8'hC, 4);
    press(3'b010, 8'h0, 4);
    check("bs_values", W'(if1.values), 64'hAB00_0000_0000_0000);
    check("bs_n", W'(if1.n_entered), W'(2));
    e0 = err1_cnt;
    press(3'b010, 8'h0, 4);
    press(3'b010, 8'h0, 4);
    check("bs_empty_n", W'(if1.n_entered), W'(0));
    check("bs_no_err_yet", W'(err1_cnt - e0), W'(0));
    press(3'b010, 8'h0, 4);
    check("bs_underflow_err", W'(err1_cnt - e0), W'(1));
    check("bs_underflow_n", W'(if1.n_entered), W'(0));
    check("bs_underflow_values", W'(if1.values), W'(0));

    // Load and clear pressed together: load wins, clear needs a fresh press.
    reset1();
    for (int i = 1; i <= 5; i++) press(3'b001, 8'(i), 4);
    press(3'b101, 8'h6, 4);
    check("simul_n", W'(if1.n_entered), W'(6));
    check("simul_values", W'(if1.values), 64'h1234_5600_0000_0000);
    check("simul_state", W'(if1.state), W'(0));
    press(3'b100, 8'h0, 4);
    check("clear_n", W'(if1.n_entered), W'(0));
    check("clear_values", W'(if1.values), W'(0));

    // Reset while LOAD_HELD, then a still-held button acts three edges later.
    reset1();
    @(posedge clk); #1;
    din = 8'h7;
    load_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("lh_state", W'(if1.state), W'(1));
    rst1 = 1'b1;
    #1;
    check("lh_rst_values", W'(if1.values), W'(0));
    check("lh_rst_n", W'(if1.n_entered), W'(0));
    check("lh_rst_state", W'(if1.state), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    din = 8'h9;
    repeat (2) @(posedge clk);
    #1;
    check("lh_edge2_n", W'(if1.n_entered), W'(0));
    @(posedge clk); #1;
    check("lh_edge3_n", W'(if1.n_entered), W'(1));
    check("lh_edge3_slot0", W'(if1.values[63:60]), W'(4'h9));
    load_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 4 x 8-bit instance.
    rst1 = 1'b1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp3_q.push_back(W'(32'hDEADBEEF));
      press(3'b001, seq3[i], 4);
    end
    check("w8_values", W'(if3.values), W'(32'hDEADBEEF));
    check("w8_valid", W'(if3.data_valid), W'(1));
    check("w8_n", W'(if3.n_entered), W'(4));
    pulse_ready(3);
    check("w8_acc_valid", W'(if3.data_valid), W'(0));
    check("w8_acc_values", W'(if3.values), W'(0));

    repeat (2) @(posedge clk);
    #1;
    check("sb1_drained", W'(exp_q.size()), W'(0));
    check("sb3_drained", W'(exp3_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
